// File: rtl/ram_timing_ctrl.sv
// ram_timing_ctrl: word-addressed main memory with a fixed access latency.
// Reports FREE/BUSY/ACCESS/ERROR. If the presented request changes while it
// waits, the latency count restarts and the earlier request is dropped.
// Optional build macro RAM_STATS_EN adds the rd_count/wr_count access counters.
module ram_timing_ctrl #(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [1:0]  ramstate,
    output logic [31:0] ramload
`ifdef RAM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    // Encoding shared with the upstream coherence controller.
    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACC  = 2'd2,
        ST_ERR  = 2'd3
    } ram_state_t;

    // Tracking state: a request has been latched and is counting down.
    typedef enum logic {
        TRK_IDLE = 1'b0,
        TRK_WAIT = 1'b1
    } trk_t;

    localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT);

    logic [31:0]      r_mem [DEPTH];
    trk_t             r_trk;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_wr;
    logic [31:0]      r_data;

    logic             w_req;
    logic             w_both;
    logic             w_oor;
    logic             w_match;
    logic [IDX_W-1:0] w_idx;
    ram_state_t       w_state;
    logic             w_unused_ok;

    assign w_req       = ramREN | ramWEN;
    assign w_both      = ramREN & ramWEN;
    assign w_oor       = |ramaddr[31:IDX_W+2];
    assign w_idx       = ramaddr[IDX_W+1:2];
    assign w_unused_ok = &{1'b0, ramaddr[1:0]};

    // A request only continues an earlier countdown if every field is unchanged.
    assign w_match = (r_trk == TRK_WAIT) && (w_idx == r_idx) &&
                     (r_wr == ramWEN) && (ramstore == r_data);

    // Per-cycle status decision, highest priority first.
    always_comb begin
        w_state = ST_FREE;
        if (w_both || (w_req && w_oor))
            w_state = ST_ERR;
        else if (!w_req)
            w_state = ST_FREE;
        else if (!w_match)
            w_state = (LAT > 0) ? ST_BUSY : ST_ACC;
        else if (r_cnt != '0)
            w_state = ST_BUSY;
        else
            w_state = ST_ACC;
    end

    assign ramstate = w_state;
    // Read data is only driven during a read's ACCESS cycle.
    assign ramload  = (w_state == ST_ACC && !ramWEN) ? r_mem[w_idx] : 32'd0;

    // Track the pending request and its remaining latency.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_trk  <= TRK_IDLE;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_wr   <= 1'b0;
            r_data <= '0;
        end else if (w_state != ST_BUSY) begin
            // FREE, ERROR and a completed ACCESS all drop the pending request.
            r_trk <= TRK_IDLE;
            r_cnt <= '0;
        end else if (!w_match) begin
            r_trk  <= TRK_WAIT;
            r_cnt  <= CNT_W'(LAT - 1);
            r_idx  <= w_idx;
            r_wr   <= ramWEN;
            r_data <= ramstore;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Commit write data at the edge closing a write's ACCESS cycle.
    always_ff @(posedge CLK) begin
        if (nRST && w_state == ST_ACC && ramWEN)
            r_mem[w_idx] <= ramstore;
    end

`ifdef RAM_STATS_EN
    // Count completed accesses by type; wraps naturally at 2^32.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (w_state == ST_ACC) begin
            if (ramWEN) wr_count <= wr_count + 32'd1;
            else        rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_timing_ctrl.sv
// Directed bench for ram_timing_ctrl: LAT=2 instance (u2) and LAT=0 instance (u0).
module tb_ram_timing_ctrl;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ramREN = 1'b0, ramWEN = 1'b0;
    logic [31:0] ramaddr = '0, ramstore = '0;
    logic [1:0]  ramstate;
    logic [31:0] ramload;
    logic        z_ren = 1'b0, z_wen = 1'b0;
    logic [31:0] z_addr = '0, z_store = '0;
    logic [1:0]  z_state;
    logic [31:0] z_load;
    int nchk = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

`ifdef RAM_STATS_EN
    logic [31:0] rd_count, wr_count, z_rdc, z_wrc;
`endif

    ram_timing_ctrl #(.LAT(2), .DEPTH(1024)) u2 (
        .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramstate(ramstate), .ramload(ramload)
`ifdef RAM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    ram_timing_ctrl #(.LAT(0), .DEPTH(1024)) u0 (
        .CLK(CLK), .nRST(nRST), .ramREN(z_ren), .ramWEN(z_wen),
        .ramaddr(z_addr), .ramstore(z_store), .ramstate(z_state), .ramload(z_load)
`ifdef RAM_STATS_EN
        , .rd_count(z_rdc), .wr_count(z_wrc)
`endif
    );

    // Present one request for one cycle on u2; returns at the mid-cycle negedge.
    task automatic cyc(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        ramREN = ren; ramWEN = wen; ramaddr = a; ramstore = d;
        @(negedge CLK);
    endtask

    task automatic cyc0(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        z_ren = ren; z_wen = wen; z_addr = a; z_store = d;
        @(negedge CLK);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLK);
        nchk++;
        if (ramstate !== FREE || ramload !== 32'd0) begin
            nerr++; $display("FAIL reset_during state=%0d load=%h want 0/0", ramstate, ramload);
        end
        @(posedge CLK); #1; nRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 32'h0, 32'h0);
            nchk++;
            if (ramstate !== FREE || ramload !== 32'd0) begin
                nerr++; $display("FAIL idle[%0d] state=%0d load=%h want 0/0", i, ramstate, ramload);
            end
        end
    endtask

    task automatic test_write_read;
        logic [1:0] exp;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 32'h40, 32'hDEADBEEF);
            exp = (i < 2) ? BUSY : ACC;
            nchk++;
            if (ramstate !== exp || ramload !== 32'd0) begin
                nerr++; $display("FAIL wr40[%0d] state=%0d load=%h want %0d/0", i, ramstate, ramload, exp);
            end
        end
        cyc(0, 0, 32'h0, 32'h0);
        nchk++;
        if (ramstate !== FREE) begin
            nerr++; $display("FAIL wr40_drop state=%0d want 0", ramstate);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 32'h40, 32'h0);
            exp = (i < 2) ? BUSY : ACC;
            nchk++;
            if (ramstate !== exp || ramload !== ((i < 2) ? 32'd0 : 32'hDEADBEEF)) begin
                nerr++; $display("FAIL rd40[%0d] state=%0d load=%h want %0d", i, ramstate, ramload, exp);
            end
        end
        // Holding the request past ACCESS starts a fresh access.
        cyc(1, 0, 32'h40, 32'h0);
        nchk++;
        if (ramstate !== BUSY || ramload !== 32'd0) begin
            nerr++; $display("FAIL held_past state=%0d load=%h want 1/0", ramstate, ramload);
        end
        cyc(0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_switch;
        logic [1:0] exp;
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h84, 32'h84848484);
        cyc(1, 0, 32'h80, 32'h0);
        nchk++;
        if (ramstate !== BUSY) begin
            nerr++; $display("FAIL sw80 state=%0d want 1", ramstate);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 32'h84, 32'h0);
            exp = (i < 2) ? BUSY : ACC;
            nchk++;
            if (ramstate !== exp || ramload !== ((i < 2) ? 32'd0 : 32'h84848484)) begin
                nerr++; $display("FAIL sw84[%0d] state=%0d load=%h want %0d", i, ramstate, ramload, exp);
            end
        end
        cyc(0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_error;
        logic [1:0] exp;
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h0, 32'hCAFEF00D);
        cyc(1, 1, 32'h0, 32'h55555555);
        nchk++;
        if (ramstate !== ERR || ramload !== 32'd0) begin
            nerr++; $display("FAIL both state=%0d load=%h want 3/0", ramstate, ramload);
        end
        cyc(0, 1, 32'h1000, 32'h0BADBAD0);
        nchk++;
        if (ramstate !== ERR) begin
            nerr++; $display("FAIL oor state=%0d want 3", ramstate);
        end
        // One BUSY, then an ERROR must clear tracking so the read restarts.
        cyc(1, 0, 32'h0, 32'h0);
        cyc(1, 1, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 32'h0, 32'h0);
            exp = (i < 2) ? BUSY : ACC;
            nchk++;
            if (ramstate !== exp || ramload !== ((i < 2) ? 32'd0 : 32'hCAFEF00D)) begin
                nerr++; $display("FAIL rd0[%0d] state=%0d load=%h want %0d", i, ramstate, ramload, exp);
            end
        end
        cyc(0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_lat0;
        cyc0(0, 1, 32'h10, 32'h1234);
        nchk++;
        if (z_state !== ACC || z_load !== 32'd0) begin
            nerr++; $display("FAIL lat0_wr state=%0d load=%h want 2/0", z_state, z_load);
        end
        for (int i = 0; i < 2; i++) begin
            cyc0(1, 0, 32'h10, 32'h0);
            nchk++;
            if (z_state !== ACC || z_load !== 32'h1234) begin
                nerr++; $display("FAIL lat0_rd[%0d] state=%0d load=%h want 2/00001234", i, z_state, z_load);
            end
        end
        cyc0(0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_stats_and_reset;
        @(posedge CLK); #1; nRST = 1'b0;
        @(posedge CLK); #1; nRST = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h100, 32'h1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h104, 32'h2);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h200, 32'h11111111);
        for (int i = 0; i < 3; i++) cyc(1, 0, 32'h100, 32'h0);
        nchk++;
        if (ramload !== 32'h1) begin
            nerr++; $display("FAIL rd100 load=%h want 00000001", ramload);
        end
        for (int i = 0; i < 3; i++) cyc(1, 0, 32'h104, 32'h0);
        nchk++;
        if (ramload !== 32'h2) begin
            nerr++; $display("FAIL rd104 load=%h want 00000002", ramload);
        end
        cyc(1, 1, 32'h100, 32'h0);
        cyc(1, 0, 32'h300, 32'h0);
        cyc(0, 0, 32'h0, 32'h0);
`ifdef RAM_STATS_EN
        nchk++;
        if (wr_count !== 32'd3 || rd_count !== 32'd2) begin
            nerr++; $display("FAIL stats wr=%0d rd=%0d want 3/2", wr_count, rd_count);
        end
`endif
        cyc(0, 1, 32'h200, 32'h22222222);
        nchk++;
        if (ramstate !== BUSY) begin
            nerr++; $display("FAIL rst_busy state=%0d want 1", ramstate);
        end
        @(posedge CLK); #1;
        ramWEN = 1'b0; ramaddr = '0; ramstore = '0; nRST = 1'b0;
        @(negedge CLK);
        nchk++;
        if (ramstate !== FREE) begin
            nerr++; $display("FAIL rst_mid state=%0d want 0", ramstate);
        end
`ifdef RAM_STATS_EN
        nchk++;
        if (wr_count !== 32'd0 || rd_count !== 32'd0) begin
            nerr++; $display("FAIL stats_rst wr=%0d rd=%0d want 0/0", wr_count, rd_count);
        end
`endif
        @(posedge CLK); #1; nRST = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1, 0, 32'h200, 32'h0);
        nchk++;
        if (ramstate !== ACC || ramload !== 32'h11111111) begin
            nerr++; $display("FAIL rd200 state=%0d load=%h want 2/11111111", ramstate, ramload);
        end
        cyc(0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_switch;
        test_error;
        test_lat0;
        test_stats_and_reset;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
